// File: rtl/fos_pkg.sv
// Shared constants for the first-order filter section and its output stages.
//   IN_W / COEF_W / OUT_W : sample, coefficient and output word widths
//   FRAC_SHIFT_DEF        : default count of filter fractional bits
//   sat_max / sat_min     : signed range limits of a w-bit two's complement word
package fos_pkg;

  localparam int IN_W           = 32;
  localparam int COEF_W         = 11;
  localparam int OUT_W          = 16;
  localparam int FRAC_SHIFT_DEF = 10;

  function automatic int sat_max(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fos_sync_fifo.sv
// Synchronous circular-buffer FIFO with a registered head word.
//   clk, reset   : clock, synchronous active-high reset
//   push         : write request (accepted if not full, or full with a pop)
//   push_data    : word to write
//   pop          : read request (ignored when empty)
//   head         : registered head entry; holds the last popped word when empty
//   full, empty  : occupancy status
//   level        : occupancy 0..DEPTH
module fos_sync_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int OUT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [OUT_W-1:0]      push_data,
  input  logic                  pop,
  output logic [OUT_W-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_LVL  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [OUT_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic                  do_push, do_pop;

  always_comb begin
    full    = (level == FULL_LVL);
    empty   = (level == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_nxt  = rd_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
      // Head register tracks mem[rd_ptr]; when the only entry is popped while
      // a new word is written, that word bypasses the array into the head.
      if (do_pop) begin
        if (level > ONE_LVL)  head <= mem[rd_nxt];
        else if (do_push)     head <= push_data;
      end else if (empty && do_push) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/fos_out_decim_fifo.sv
// Output conditioning for the first-order IIR section: integrate-and-dump
// decimation by 2**DECIM_LOG2, round-half-up and saturate to OUT_W bits, then
// buffer in a FIFO toward the consumer.
//   clk, reset   : clock, synchronous active-high reset
//   y_in         : signed filter sample, qualified by in_valid
//   out_data     : FIFO head word (signed), out_valid when FIFO non-empty
//   out_ready    : consumer accept; pop on out_valid && out_ready
//   level        : FIFO occupancy
//   sat_flag     : sticky, some output word was clipped
//   ovf_flag     : sticky, some word was dropped on a full FIFO
//   clear_flags  : clears both sticky flags (wins over a same-cycle set)
module fos_out_decim_fifo
  import fos_pkg::*;
#(
  parameter int IN_W       = fos_pkg::IN_W,
  parameter int OUT_W      = fos_pkg::OUT_W,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int DECIM_LOG2 = 2,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [IN_W-1:0]   y_in,
  input  logic                     in_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH_LOG2:0]      level,
  output logic                     sat_flag,
  output logic                     ovf_flag,
  input  logic                     clear_flags
);

  localparam int ACC_W = IN_W + DECIM_LOG2;
  localparam int RW    = ACC_W + 1;
  localparam int SH    = FRAC_SHIFT + DECIM_LOG2;
  localparam logic signed [RW-1:0] HALF  = {{(RW-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [RW-1:0] R_MAX = RW'(sat_max(OUT_W));
  localparam logic signed [RW-1:0] R_MIN = RW'(sat_min(OUT_W));

  logic signed [ACC_W-1:0]  acc, acc_sum, s2_sum;
  logic [DECIM_LOG2-1:0]    phase;
  logic                     s2_valid;
  logic signed [RW-1:0]     rsum, r;
  logic [OUT_W-1:0]         word;
  logic                     clip, pop, full, empty, drop;

  always_comb begin
    acc_sum = acc + {{DECIM_LOG2{y_in[IN_W-1]}}, y_in};
    rsum    = {s2_sum[ACC_W-1], s2_sum} + HALF;
    r       = rsum >>> SH;
    clip    = 1'b0;
    word    = r[OUT_W-1:0];
    if (r > R_MAX) begin
      word = R_MAX[OUT_W-1:0];
      clip = 1'b1;
    end else if (r < R_MIN) begin
      word = R_MIN[OUT_W-1:0];
      clip = 1'b1;
    end
    out_valid = !empty;
    pop       = out_valid && out_ready;
    drop      = s2_valid && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      phase    <= '0;
      s2_sum   <= '0;
      s2_valid <= 1'b0;
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      s2_valid <= 1'b0;
      if (in_valid) begin
        phase <= phase + 1'b1;
        if (phase == '1) begin
          s2_sum   <= acc_sum;
          s2_valid <= 1'b1;
          acc      <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
      if (clear_flags) begin
        sat_flag <= 1'b0;
        ovf_flag <= 1'b0;
      end else begin
        if (s2_valid && clip) sat_flag <= 1'b1;
        if (drop)             ovf_flag <= 1'b1;
      end
    end
  end

  fos_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .OUT_W      (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s2_valid),
    .push_data (word),
    .pop       (pop),
    .head      (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

endmodule

// File: tb/tb_fos_out_decim_fifo.sv
module tb_fos_out_decim_fifo;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [31:0] y_in;
  logic               in_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         level;
  logic               sat_flag;
  logic               ovf_flag;
  logic               clear_flags;

  int n_cmp  = 0;
  int n_fail = 0;

  fos_out_decim_fifo #(
    .IN_W       (32),
    .OUT_W      (16),
    .FRAC_SHIFT (10),
    .DECIM_LOG2 (2),
    .DEPTH_LOG2 (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .y_in        (y_in),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .sat_flag    (sat_flag),
    .ovf_flag    (ovf_flag),
    .clear_flags (clear_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic signed [31:0] y;
    int                 exp_data;
    int                 exp_sat;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Four samples of y; gapped inserts an idle cycle after each sample.
  task automatic block(input logic signed [31:0] y, input bit gapped);
    for (int i = 0; i < 4; i++) begin
      y_in     = y;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (gapped) tick();
    end
  endtask

  task automatic pop_expect(input string name, input int exp);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_data"}, int'(out_data), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"const1024",    32'sd1024,    1,      0};
    vecs[1] = '{"half512",      32'sd512,     1,      0};
    vecs[2] = '{"neg2048",      -32'sd2048,   -2,     0};
    vecs[3] = '{"negtie512",    -32'sd512,    0,      0};
    vecs[4] = '{"pos3000",      32'sd3000,    3,      0};
    vecs[5] = '{"neg3000",      -32'sd3000,   -3,     0};
    vecs[6] = '{"below_half",   32'sd2047,    2,      0};
    vecs[7] = '{"sat_max",      32'sh7FFFFFFF, 32767, 1};
    vecs[8] = '{"sat_min",      32'sh80000000, -32768, 1};

    reset = 1'b1; y_in = '0; in_valid = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data",  int'(out_data),  0);
    check("rst_level", int'(level),     0);
    check("rst_sat",   int'(sat_flag),  0);
    check("rst_ovf",   int'(ovf_flag),  0);

    // Table: one block per vector, latency, value, flag, pop and hold.
    foreach (vecs[k]) begin
      clear();
      block(vecs[k].y, 1'b0);
      check({vecs[k].name, "_lat"}, int'(out_valid), 0);
      tick();
      check({vecs[k].name, "_lvl"}, int'(level), 1);
      check({vecs[k].name, "_sat"}, int'(sat_flag), vecs[k].exp_sat);
      pop_expect(vecs[k].name, vecs[k].exp_data);
      check({vecs[k].name, "_empty"}, int'(out_valid), 0);
      check({vecs[k].name, "_hold"}, int'(out_data), vecs[k].exp_data);
    end

    // Sat flag is sticky across a non-clipping word, cleared by clear_flags.
    block(32'sd1024, 1'b0);
    tick();
    check("sticky_sat", int'(sat_flag), 1);
    pop_expect("sticky_word", 1);
    clear();
    check("clear_sat", int'(sat_flag), 0);

    // clear_flags during the clipping stage-2 cycle wins; event is lost.
    block(32'sh7FFFFFFF, 1'b0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("clr_prio_sat", int'(sat_flag), 0);
    pop_expect("clr_prio_word", 32767);

    // Overflow: 9 blocks, no consumer.
    for (int b = 0; b < 9; b++) block(32'sd1024, 1'b0);
    tick();
    check("ovf_level", int'(level), 8);
    check("ovf_flag", int'(ovf_flag), 1);
    for (int i = 0; i < 8; i++) pop_expect("ovf_drain", 1);
    check("ovf_drained", int'(out_valid), 0);
    check("ovf_level0", int'(level), 0);
    check("ovf_sticky", int'(ovf_flag), 1);
    clear();
    check("ovf_clear", int'(ovf_flag), 0);

    // Full FIFO with a pop on the push cycle: word accepted, no overflow.
    for (int b = 0; b < 8; b++) block(32'sd1024, 1'b0);
    tick();
    check("full_level", int'(level), 8);
    block(32'sd4096, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fullpop_level", int'(level), 8);
    check("fullpop_ovf", int'(ovf_flag), 0);
    for (int i = 0; i < 7; i++) pop_expect("fullpop_drain", 1);
    pop_expect("fullpop_last", 4);
    check("fullpop_empty", int'(out_valid), 0);

    // Level 1 with simultaneous push and pop: new word becomes head.
    block(32'sd1024, 1'b0);
    tick();
    block(32'sd4096, 1'b0);
    check("l1_head_old", int'(out_data), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("l1_level", int'(level), 1);
    check("l1_head_new", int'(out_data), 4);
    pop_expect("l1_pop", 4);

    // Gapped input gives the same word as back-to-back input.
    block(32'sd3000, 1'b1);
    tick();
    check("gap_level", int'(level), 1);
    pop_expect("gap_word", 3);

    // Reset mid-block discards the partial sum.
    y_in = 32'sd100000; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    block(32'sd1024, 1'b0);
    tick();
    check("rstmid_level", int'(level), 1);
    pop_expect("rstmid_word", 1);
    tick(); tick(); tick();
    check("rstmid_only", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
